// File: rtl/x3q16_mem_pkg.sv
// rtl/x3q16_mem_pkg.sv - shared opcodes, state encoding and frame helpers for the x3q16 SPI memory stage
package x3q16_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] MODE_SEQ = 8'h40;

  localparam int FRAME_BITS = 48;
  localparam int INIT_BITS  = 16;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // CPU word address -> even SRAM byte address; data high byte goes to the even byte
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0]  op,
                                                        input logic [15:0] word_addr,
                                                        input logic [15:0] data);
    return {op, 7'b0, word_addr, 1'b0, data};
  endfunction

endpackage

// File: rtl/x3q16_spi_shifter.sv
// rtl/x3q16_spi_shifter.sv - mode-0 SPI frame engine: SCK divider, MSB-first shift register, bit counter
module x3q16_spi_shifter
  import x3q16_mem_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [5:0]            bit_count_init,
  input  logic                  spi_miso,
  output logic                  done,
  output logic [15:0]           rx_data,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_mosi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic                  active;
  logic [DW-1:0]         div_cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  half_end;

  // MOSI is the shift register MSB; clearing shreg at frame end parks MOSI low
  assign spi_mosi = shreg[FRAME_BITS-1];
  assign half_end = active && (div_cnt == DIV_LAST);
  assign done     = half_end && spi_sck && (bit_cnt == 6'd0);

  // Half-period sequencing: rise samples MISO, fall shifts the next MOSI bit or closes the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= 6'd0;
      shreg    <= '0;
      rx_data  <= 16'h0000;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= bit_count_init;
      shreg    <= frame;
      spi_cs_n <= 1'b0;
      spi_sck  <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!spi_sck) begin
          spi_sck <= 1'b1;
          rx_data <= {rx_data[14:0], spi_miso};
        end else if (bit_cnt == 6'd0) begin
          active   <= 1'b0;
          spi_cs_n <= 1'b1;
          spi_sck  <= 1'b0;
          shreg    <= '0;
        end else begin
          spi_sck <= 1'b0;
          bit_cnt <= bit_cnt - 6'd1;
          shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/x3q16_spi_mem.sv
// rtl/x3q16_spi_mem.sv - CPU word request to SPI SRAM bridge; X3Q16_SPI_MEM_INIT_EN adds a WRMR setup frame after reset
module x3q16_spi_mem
  import x3q16_mem_pkg::*;
#(
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] READ_CMD  = OP_READ,
  parameter logic [7:0] WRITE_CMD = OP_WRITE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_out,
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);
`ifdef X3Q16_SPI_MEM_INIT_EN
  localparam logic [5:0] INIT_LAST   = 6'(INIT_BITS - 1);
  localparam state_t     RESET_STATE = ST_INIT;
`else
  localparam state_t     RESET_STATE = ST_IDLE;
`endif

  state_t                state, state_nxt;
  logic                  request_q;
  logic                  type_q;
  logic                  accept;
  logic                  sh_start;
  logic [FRAME_BITS-1:0] sh_frame;
  logic [5:0]            sh_last;
  logic                  sh_done;
  logic [15:0]           rx_data;
`ifdef X3Q16_SPI_MEM_INIT_EN
  logic [1:0]            init_step, init_step_nxt;
`endif

  x3q16_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk            (clk),
    .reset          (reset),
    .start          (sh_start),
    .frame          (sh_frame),
    .bit_count_init (sh_last),
    .spi_miso       (spi_miso),
    .done           (sh_done),
    .rx_data        (rx_data),
    .spi_cs_n       (spi_cs_n),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi)
  );

  // Next state and shifter launch; request fields are captured straight into the shift register
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sh_start  = 1'b0;
    sh_last   = FRAME_LAST;
    sh_frame  = build_frame(request_type ? WRITE_CMD : READ_CMD, request_address,
                            request_type ? data_out : 16'h0000);
`ifdef X3Q16_SPI_MEM_INIT_EN
    init_step_nxt = init_step;
`endif
    case (state)
      ST_INIT: begin
`ifdef X3Q16_SPI_MEM_INIT_EN
        case (init_step)
          2'd0: begin
            sh_start      = 1'b1;
            sh_frame      = {OP_WRMR, MODE_SEQ, 32'h0};
            sh_last       = INIT_LAST;
            init_step_nxt = 2'd1;
          end
          2'd1: if (sh_done) init_step_nxt = 2'd2;
          2'd2: init_step_nxt = 2'd3;
          default: state_nxt = ST_IDLE;
        endcase
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (request && !request_q) begin
          accept    = 1'b1;
          sh_start  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: if (sh_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, request edge history, transaction type and read-data holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RESET_STATE;
      request_q <= 1'b0;
      type_q    <= 1'b0;
      memory_in <= 16'h0000;
    end else begin
      state     <= state_nxt;
      request_q <= request;
      if (accept) type_q <= request_type;
      if (state == ST_SHIFT && sh_done && !type_q) memory_in <= rx_data;
    end
  end

`ifdef X3Q16_SPI_MEM_INIT_EN
  // Sub-step of the setup sequence: launch, wait for frame end, two-cycle cs_n-high gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) init_step <= 2'd0;
    else        init_step <= init_step_nxt;
  end
`endif

  assign memory_ready    = (state == ST_DONE);
  assign memory_critical = (state != ST_IDLE);
  assign write_complete  = !((state == ST_SHIFT) && type_q);

endmodule

// File: tb/tb_x3q16_spi_mem.sv
// tb/tb_x3q16_spi_mem.sv - directed scoreboard bench for x3q16_spi_mem with behavioural SPI SRAM models
module tb_x3q16_spi_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, type_a, rdy_a, wc_a, crit_a, cs_a, sck_a, mosi_a, miso_a;
  logic [15:0] addr_a, wdata_a, min_a;
  logic        req_b, type_b, rdy_b, wc_b, crit_b, cs_b, sck_b, mosi_b, miso_b;
  logic [15:0] addr_b, wdata_b, min_b;

  x3q16_spi_mem #(.CLK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .request(req_a), .request_type(type_a),
    .request_address(addr_a), .data_out(wdata_a), .memory_in(min_a),
    .memory_ready(rdy_a), .write_complete(wc_a), .memory_critical(crit_a),
    .spi_cs_n(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  x3q16_spi_mem #(.CLK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .request(req_b), .request_type(type_b),
    .request_address(addr_b), .data_out(wdata_b), .memory_in(min_b),
    .memory_ready(rdy_b), .write_complete(wc_b), .memory_critical(crit_b),
    .spi_cs_n(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

`ifdef X3Q16_SPI_MEM_INIT_EN
  localparam logic CRIT_RST = 1'b1;
`else
  localparam logic CRIT_RST = 1'b0;
`endif

  // SRAM model A: byte array, write capture, read data driven on SCK falling edges
  logic [7:0]  mem [0:255];
  logic [47:0] fr_a, last_fr_a;
  int          bits_a, last_bits_a, frames_a;
  logic [23:0] baddr_a;
  logic [15:0] rw_a;

  initial begin
    miso_a = 1'b0; fr_a = '0; bits_a = 0; frames_a = 0; last_fr_a = '0; last_bits_a = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(negedge cs_a) begin
    bits_a = 0; fr_a = '0; frames_a++;
  end

  always @(posedge cs_a) begin
    last_fr_a = fr_a; last_bits_a = bits_a;
  end

  always @(posedge sck_a) if (cs_a === 1'b0) begin
    fr_a = {fr_a[46:0], mosi_a};
    bits_a++;
    if (bits_a == 32) baddr_a = fr_a[23:0];
    if (bits_a == 40 && fr_a[39:32] == 8'h02) mem[baddr_a[7:0]] = fr_a[7:0];
    if (bits_a == 48 && fr_a[47:40] == 8'h02) mem[baddr_a[7:0] + 8'd1] = fr_a[7:0];
  end

  always @(negedge sck_a) if (cs_a === 1'b0 && bits_a >= 32 && bits_a < 48) begin
    rw_a   = {mem[baddr_a[7:0]], mem[baddr_a[7:0] + 8'd1]};
    miso_a = rw_a[47 - bits_a];
  end

  // SRAM model B: frame capture and a fixed read word
  logic [47:0] fr_b, last_fr_b;
  int          bits_b;
  logic [15:0] bword;

  initial begin
    miso_b = 1'b0; fr_b = '0; bits_b = 0; last_fr_b = '0; bword = 16'h5AC3;
  end

  always @(negedge cs_b) begin
    bits_b = 0; fr_b = '0;
  end

  always @(posedge cs_b) last_fr_b = fr_b;

  always @(posedge sck_b) if (cs_b === 1'b0) begin
    fr_b = {fr_b[46:0], mosi_b};
    bits_b++;
  end

  always @(negedge sck_b) if (cs_b === 1'b0 && bits_b >= 32 && bits_b < 48)
    miso_b = bword[47 - bits_b];

  typedef struct {
    logic [47:0] frame;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input logic [15:0] exp_min);
    exp_t e;
    int   cnt;
    logic bad;
    e.frame = {wr ? 8'h02 : 8'h03, 7'b0, addr, 1'b0, wr ? data : 16'h0000};
    e.rd    = exp_min;
    sb.push_back(e);
    req_a = 1'b1; type_a = wr; addr_a = addr; wdata_a = data;
    step();
    req_a = 1'b0;
    cnt = 1; bad = 1'b0;
    while (rdy_a !== 1'b1 && cnt < 400) begin
      if (cs_a !== 1'b0 || crit_a !== 1'b1 || wc_a !== !wr) bad = 1'b1;
      step();
      cnt++;
    end
    e = sb.pop_front();
    chk({tag, " busy_outputs"}, bad, 1'b0);
    chk({tag, " latency"}, cnt, 97);
    chk({tag, " cs_n_at_done"}, cs_a, 1'b1);
    chk({tag, " wc_at_done"}, wc_a, 1'b1);
    chk({tag, " frame"}, last_fr_a, e.frame);
    chk({tag, " frame_bits"}, last_bits_a, 48);
    chk({tag, " memory_in"}, min_a, e.rd);
    step();
    chk({tag, " ready_one_cycle"}, {rdy_a, crit_a}, 2'b00);
  endtask

  initial begin
    int   pulses, f0, cnt;
    reset = 1'b0;
    req_a = 1'b0; type_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; type_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) step();
    chk("rst memory_in", min_a, 16'h0000);
    chk("rst memory_ready", rdy_a, 1'b0);
    chk("rst write_complete", wc_a, 1'b1);
    chk("rst memory_critical", crit_a, CRIT_RST);
    chk("rst spi_cs_n", cs_a, 1'b1);
    chk("rst spi_sck", sck_a, 1'b0);
    chk("rst spi_mosi", mosi_a, 1'b0);
    chk("rst b spi_cs_n", cs_b, 1'b1);
    reset = 1'b1;
    step();

`ifdef X3Q16_SPI_MEM_INIT_EN
    req_a = 1'b1; type_a = 1'b0; addr_a = 16'h0000;
    step();
    req_a = 1'b0;
    cnt = 0;
    while (crit_a === 1'b1 && cnt < 300) begin step(); cnt++; end
    chk("init frame", last_fr_a[15:0], 16'h0140);
    chk("init frame_bits", last_bits_a, 16);
    f0 = frames_a;
    repeat (120) step();
    chk("init request dropped", frames_a - f0, 0);
`endif
    cnt = 0;
    while ((crit_a === 1'b1 || crit_b === 1'b1) && cnt < 500) begin step(); cnt++; end

    xfer("wr 0012", 1'b1, 16'h0012, 16'hBEEF, 16'h0000);
    xfer("rd 0012", 1'b0, 16'h0012, 16'h0000, 16'hBEEF);

    f0 = frames_a; pulses = 0;
    req_a = 1'b1; type_a = 1'b0; addr_a = 16'h0012;
    for (int i = 0; i < 300; i++) begin
      step();
      if (rdy_a === 1'b1) pulses++;
    end
    chk("held pulses", pulses, 1);
    chk("held frames", frames_a - f0, 1);
    chk("held memory_in", min_a, 16'hBEEF);
    req_a = 1'b0;
    step();
    xfer("wr 0013", 1'b1, 16'h0013, 16'h1234, 16'hBEEF);
    xfer("rd 0013", 1'b0, 16'h0013, 16'h0000, 16'h1234);

    req_a = 1'b1; type_a = 1'b1; addr_a = 16'h0040; wdata_a = 16'hA5A5;
    step();
    req_a = 1'b0;
    repeat (39) step();
    reset = 1'b0;
    #1;
    chk("abort spi_cs_n", cs_a, 1'b1);
    chk("abort spi_sck", sck_a, 1'b0);
    chk("abort spi_mosi", mosi_a, 1'b0);
    chk("abort memory_in", min_a, 16'h0000);
    chk("abort memory_ready", rdy_a, 1'b0);
    chk("abort write_complete", wc_a, 1'b1);
    chk("abort memory_critical", crit_a, CRIT_RST);
    pulses = 0;
    repeat (3) begin step(); if (rdy_a === 1'b1) pulses++; end
    reset = 1'b1;
    repeat (150) begin step(); if (rdy_a === 1'b1) pulses++; end
    chk("abort no ready", pulses, 0);
    cnt = 0;
    while ((crit_a === 1'b1 || crit_b === 1'b1) && cnt < 500) begin step(); cnt++; end

    req_b = 1'b1; type_b = 1'b0; addr_b = 16'hFFFF;
    step();
    req_b = 1'b0;
    cnt = 1;
    while (rdy_b !== 1'b1 && cnt < 600) begin step(); cnt++; end
    chk("div3 latency", cnt, 289);
    chk("div3 frame", last_fr_b, 48'h0301FFFE0000);
    chk("div3 memory_in", min_b, 16'h5AC3);
    chk("div3 cs_n_at_done", cs_b, 1'b1);
    chk("div3 wc", wc_b, 1'b1);
    step();
    chk("div3 ready_one_cycle", {rdy_b, crit_b}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/x3q16_spi_mem.md
Name: x3q16_spi_mem

Overview:
- Memory-side stage directly downstream of the x3q16 core's memory port.
- Converts single-word CPU read/write requests into SPI transactions to an external 24-bit-address serial SRAM (1 Mbit class).
- Returns read data to the core with the memory_ready / write_complete handshake.
- One transaction in flight at a time. CPU word address maps to two consecutive big-endian bytes.

Parameters:
- CLK_DIV, 1: SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV).
- READ_CMD, 8'h03: SPI read opcode.
- WRITE_CMD, 8'h02: SPI write opcode.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- request  in  1  CPU request; level, edge-detected.
- request_type  in  1  1 = write, 0 = read; sampled at acceptance.
- request_address  in  16  word address; sampled at acceptance.
- data_out  in  16  CPU write data; sampled at acceptance.
- memory_in  out  16  read data to CPU.
- memory_ready  out  1  one-cycle completion pulse (read or write).
- write_complete  out  1  high when no write is in flight.
- memory_critical  out  1  high while a transaction is busy (CPU must not issue).
- spi_cs_n  out  1  SRAM chip select, active low.
- spi_sck  out  1  SPI clock, mode 0.
- spi_mosi  out  1  serial data to SRAM.
- spi_miso  in  1  serial data from SRAM.

Behaviour:
- Reset values: memory_in=0, memory_ready=0, write_complete=1, memory_critical=0, spi_cs_n=1, spi_sck=0, spi_mosi=0. State=IDLE (or INIT when the optional feature is enabled).
- Reset asserted mid-transaction aborts immediately: cs_n high, no memory_ready pulse, memory_in cleared.
- Acceptance: in IDLE, request high with request_q (registered previous value) low. Latch type, address and data.
- A request held high for many cycles yields exactly one transaction. A request edge while busy is dropped.
- Frame is 48 bits, MSB first: opcode[7:0], byte address {7'b0, addr[15:0], 1'b0}[23:0], then data[15:0] (high byte = even byte address).
- Writes shift data_out on MOSI. Reads drive MOSI=0 during the data phase.
- SPI mode 0: MOSI updates while SCK low (at cs_n fall, then on each SCK falling edge); MISO is sampled on the SCK rising edge.
- States: IDLE -> SHIFT -> DONE -> IDLE.
  - SHIFT: 6-bit bit counter 47..0 plus divider counter.
  - DONE: cs_n high, SCK low.
- Latency with CLK_DIV=1, acceptance at cycle A:
  - cs_n falls at A+1.
  - 48 SCK periods occupy A+1..A+96.
  - DONE at A+97: cs_n=1, memory_ready=1 for exactly one cycle.
  - IDLE at A+98; next acceptance possible at A+98.
  - General case: busy for 96*CLK_DIV cycles.
- memory_in updates only at a read's DONE cycle and holds until the next read completes. Writes leave memory_in unchanged.
- write_complete falls in the cycle after a write is accepted and rises at DONE.
- memory_critical is high from the cycle after acceptance through DONE.
- Address 16'hFFFF maps to byte address 0x01FFFE; no wrap handling beyond 24 bits is needed.

Optional Feature:
- Macro X3Q16_SPI_MEM_INIT_EN.
- Defined:
  - After reset release, state INIT sends WRMR (8'h01, 8'h40 = sequential mode) as one 16-bit frame, followed by a 2-cycle cs_n-high gap, before entering IDLE.
  - memory_critical=1 throughout INIT. Requests during INIT are dropped, but an edge pending at INIT exit is not accepted.
- Undefined: the block enters IDLE directly after reset.

Decomposition:
- Package x3q16_mem_pkg holds:
  - SPI opcodes (READ 03, WRITE 02, WRMR 01, MODE_SEQ 40);
  - state encoding (INIT, IDLE, SHIFT, DONE);
  - FRAME_BITS=48 and INIT_BITS=16.
- One natural sub-module: x3q16_spi_shifter, covering the SCK divider, 48-bit shift register and bit counter with start/done handshake. The top level keeps the request edge detect, the FSM and the CPU-side outputs.

Test Plan:
- Write addr 16'h0012, data 16'hBEEF, CLK_DIV=1 -> MOSI frame 02_000024_BEEF. write_complete low A+1..A+96. memory_ready pulse at A+97 only.
- SRAM model holds bytes 0x000024=BE, 0x000025=EF; read addr 16'h0012 -> frame 03_000024, memory_in=16'hBEEF at A+97, memory_ready one cycle, write_complete stays 1.
- Request held high for 300 cycles -> exactly one transaction and one memory_ready pulse. Second edge after IDLE -> second transaction.
- Reset pulled low at A+40 of a write -> cs_n=1 and sck=0 asynchronously. No memory_ready. Outputs return to reset values.
- Read addr 16'hFFFF with CLK_DIV=3 -> address bits 01FFFE, busy 288 cycles, memory_ready at A+289.
- With X3Q16_SPI_MEM_INIT_EN defined -> first frame after reset is 01_40. A request edge during INIT is dropped. memory_critical falls only when IDLE is reached.
